// File: rtl/paddle_pos_filter.sv
// Paddle position filter: BUSY-synchronised capture, block averaging, scaling
// to 0..Y_MAX and deadband. Optional stall watchdog when ADC_WATCHDOG_EN is defined.
module paddle_pos_filter #(
  parameter int AVG_LOG2    = 3,
  parameter int Y_MAX       = 440,
  parameter int DEADBAND    = 2,
  parameter int WDOG_CYCLES = 5000000
) (
  input  logic        CLOCK_50MHz,
  input  logic        RESET_n,
  input  logic        BUSY,
  input  logic [11:0] DATA_AD0,
  input  logic [11:0] DATA_AD1,
  output logic [9:0]  PADDLE0_Y,
  output logic [9:0]  PADDLE1_Y,
  output logic        POS_VALID,
  output logic        ADC_STALL
);

  localparam int                    ACC_W    = 12 + AVG_LOG2;
  localparam logic [9:0]            Y_CENTER = 10'(Y_MAX / 2);
  localparam logic [AVG_LOG2-1:0]   CNT_LAST = '1;
  localparam logic signed [10:0]    DB       = 11'(DEADBAND);

  typedef enum logic [2:0] {IDLE, ACCUM, SCALE0, SCALE1, UPDATE} state_t;

  state_t              state, state_next;
  logic                busy_s1, busy_s2, busy_hist;
  logic                fall_det;
  logic                pending;
  logic [ACC_W-1:0]    acc0, acc1;
  logic [AVG_LOG2-1:0] cnt;
  logic [9:0]          y0;
  logic [11:0]         mult_a;
  logic [21:0]         mult_p;
  logic [9:0]          y_scaled;
  logic                stall_hold;
  logic                stall_force;
  logic                wd_pulse;

  assign fall_det = busy_hist & ~busy_s2;

  // One multiplier serves both channels; SCALE1 selects channel 1.
  assign mult_a   = (state == SCALE1) ? acc1[ACC_W-1:AVG_LOG2] : acc0[ACC_W-1:AVG_LOG2];
  assign mult_p   = 22'(mult_a) * 22'(Y_MAX + 1);
  assign y_scaled = 10'(mult_p >> 12);

  function automatic logic [9:0] deadband(input logic [9:0] y_new, input logic [9:0] cur);
    logic signed [10:0] diff;
    diff = $signed({1'b0, y_new}) - $signed({1'b0, cur});
    if ((diff > DB) || (diff < -DB))
      return y_new;
    else
      return cur;
  endfunction

  always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
    if (!RESET_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending) state_next = ACCUM;
      ACCUM:   state_next = (cnt == CNT_LAST) ? SCALE0 : IDLE;
      SCALE0:  state_next = SCALE1;
      SCALE1:  state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (stall_hold)
      state_next = IDLE;
  end

  always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      busy_s1   <= 1'b1;
      busy_s2   <= 1'b1;
      busy_hist <= 1'b1;
      pending   <= 1'b0;
      acc0      <= '0;
      acc1      <= '0;
      cnt       <= '0;
      y0        <= '0;
      PADDLE0_Y <= Y_CENTER;
      PADDLE1_Y <= Y_CENTER;
    end else begin
      busy_s1   <= BUSY;
      busy_s2   <= busy_s1;
      busy_hist <= busy_s2;
      // A new edge wins over consumption; an edge while already pending is lost.
      pending   <= fall_det | (pending & ~(state == IDLE));
      case (state)
        ACCUM: begin
          acc0 <= acc0 + ACC_W'(DATA_AD0);
          acc1 <= acc1 + ACC_W'(DATA_AD1);
          cnt  <= cnt + AVG_LOG2'(1);
        end
        SCALE0: y0 <= y_scaled;
        SCALE1: begin
          PADDLE0_Y <= deadband(y0, PADDLE0_Y);
          PADDLE1_Y <= deadband(y_scaled, PADDLE1_Y);
        end
        UPDATE: begin
          acc0 <= '0;
          acc1 <= '0;
          cnt  <= '0;
        end
        default: ;
      endcase
      if (stall_hold) begin
        acc0 <= '0;
        acc1 <= '0;
        cnt  <= '0;
      end
      if (stall_force) begin
        PADDLE0_Y <= Y_CENTER;
        PADDLE1_Y <= Y_CENTER;
      end
    end
  end

  assign POS_VALID = (state == UPDATE) | wd_pulse;

`ifdef ADC_WATCHDOG_EN
  localparam logic [22:0] WDOG_LIMIT = 23'(WDOG_CYCLES);

  logic [22:0] wdog_cnt;
  logic        stall, stall_d;

  // Counter parks at the limit while stalled; the next edge restarts everything.
  always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      wdog_cnt <= '0;
      stall    <= 1'b0;
      stall_d  <= 1'b0;
      wd_pulse <= 1'b0;
    end else begin
      stall_d  <= stall;
      wd_pulse <= stall_force;
      if (fall_det) begin
        wdog_cnt <= '0;
        stall    <= 1'b0;
      end else begin
        if (wdog_cnt != WDOG_LIMIT)
          wdog_cnt <= wdog_cnt + 23'd1;
        if (wdog_cnt == WDOG_LIMIT)
          stall <= 1'b1;
      end
    end
  end

  assign stall_hold  = stall;
  assign stall_force = stall & ~stall_d;
  assign ADC_STALL   = stall;
`else
  assign stall_hold  = 1'b0;
  assign stall_force = 1'b0;
  assign wd_pulse    = 1'b0;
  // No watchdog: constant-false expression keeps ADC_STALL low.
  assign ADC_STALL   = (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_paddle_pos_filter.sv
// Randomised self-checking bench for paddle_pos_filter against an arithmetic
// block-average model; the watchdog scenario runs when ADC_WATCHDOG_EN is defined.
module tb_paddle_pos_filter;
  localparam int Y_MAX  = 440;
  localparam int DBAND  = 2;
  localparam int AVG_N  = 8;
  localparam int WDOG   = 1000;
  localparam int CENTER = 220;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy  = 1'b1;
  logic [11:0] d0    = '0;
  logic [11:0] d1    = '0;
  logic [9:0]  p0, p1;
  logic        pv, stall;

  always #10 clk = ~clk;

  paddle_pos_filter #(.AVG_LOG2(3), .Y_MAX(Y_MAX), .DEADBAND(DBAND), .WDOG_CYCLES(WDOG)) dut (
    .CLOCK_50MHz(clk), .RESET_n(rst_n), .BUSY(busy), .DATA_AD0(d0), .DATA_AD1(d1),
    .PADDLE0_Y(p0), .PADDLE1_Y(p1), .POS_VALID(pv), .ADC_STALL(stall));

  int vectors = 0, miscompares = 0;
  int pulse_cnt = 0, exp_pulses = 0;
  int m0 = CENTER, m1 = CENTER, sum0 = 0, sum1 = 0, nsamp = 0;

  always @(negedge clk) if (pv === 1'b1) pulse_cnt <= pulse_cnt + 1;

  function automatic int scale(input int sum);
    return ((sum / AVG_N) * (Y_MAX + 1)) / 4096;
  endfunction

  task automatic model_reset();
    m0 = CENTER; m1 = CENTER; sum0 = 0; sum1 = 0; nsamp = 0;
  endtask

  task automatic model_push(input int a, input int b);
    int y;
    sum0 += a; sum1 += b; nsamp++;
    if (nsamp == AVG_N) begin
      y = scale(sum0);
      if (y - m0 > DBAND || m0 - y > DBAND) m0 = y;
      y = scale(sum1);
      if (y - m1 > DBAND || m1 - y > DBAND) m1 = y;
      exp_pulses++;
      sum0 = 0; sum1 = 0; nsamp = 0;
    end
  endtask

  task automatic send_sample(input int a, input int b);
    @(negedge clk);
    d0 = 12'(a); d1 = 12'(b); busy = 1'b0;
    repeat (4) @(negedge clk);
    busy = 1'b1;
    repeat (8) @(negedge clk);
    model_push(a, b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; busy = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; busy = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors += 4;
    if (p0 !== 10'd220) begin miscompares++; $display("FAIL reset_p0: got %0d expected 220", p0); end
    if (p1 !== 10'd220) begin miscompares++; $display("FAIL reset_p1: got %0d expected 220", p1); end
    if (pv !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", pv); end
    if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", stall); end
    repeat (900) @(negedge clk);
    vectors++;
    if (pulse_cnt !== 0) begin miscompares++; $display("FAIL idle_pulses: got %0d expected 0", pulse_cnt); end
    $display("reset: P0=%0d P1=%0d pulses=%0d", p0, p1, pulse_cnt);
  endtask

  task automatic test_full_scale();
    int lat = 0;
    for (int i = 0; i < 7; i++) send_sample(4095, 0);
    vectors++;
    if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL fs_early_pulse: got %0d expected %0d", pulse_cnt, exp_pulses); end
    @(negedge clk);
    d0 = 12'd4095; d1 = 12'd0; busy = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 4) busy = 1'b1;
      if (pv === 1'b1 && lat == 0) lat = i;
    end
    model_push(4095, 0);
    vectors += 4;
    // 3 cycles to the pending flag (2-FF sync + edge detect), then 4 more
    if (lat !== 7) begin miscompares++; $display("FAIL fs_latency: got %0d expected 7", lat); end
    if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL fs_pulses: got %0d expected %0d", pulse_cnt, exp_pulses); end
    if (p0 !== 10'd440) begin miscompares++; $display("FAIL fs_p0: got %0d expected 440", p0); end
    if (p1 !== 10'd0) begin miscompares++; $display("FAIL fs_p1: got %0d expected 0", p1); end
    $display("full_scale: P0=%0d P1=%0d latency=%0d pulses=%0d", p0, p1, lat, pulse_cnt);
  endtask

  task automatic test_deadband();
    do_reset();
    for (int i = 0; i < 8; i++) send_sample(2056, 2056);
    vectors += 3;
    if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL db_pulses: got %0d expected %0d", pulse_cnt, exp_pulses); end
    if (p0 !== 10'd220) begin miscompares++; $display("FAIL db_hold_p0: got %0d expected 220", p0); end
    if (p1 !== 10'(m1)) begin miscompares++; $display("FAIL db_hold_p1: got %0d expected %0d", p1, m1); end
    $display("deadband hold: P0=%0d P1=%0d", p0, p1);
    for (int i = 0; i < 8; i++) send_sample(2072, 2072);
    vectors += 2;
    if (p0 !== 10'd223) begin miscompares++; $display("FAIL db_move_p0: got %0d expected 223", p0); end
    if (p1 !== 10'(m1)) begin miscompares++; $display("FAIL db_move_p1: got %0d expected %0d", p1, m1); end
    $display("deadband move: P0=%0d P1=%0d", p0, p1);
  endtask

  task automatic test_reset_mid_block();
    do_reset();
    for (int i = 0; i < 8; i++) send_sample(4095, 4095);
    for (int i = 0; i < 5; i++) send_sample(4095, 4095);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (p0 !== 10'd220) begin miscompares++; $display("FAIL mid_rst_p0: got %0d expected 220", p0); end
    if (p1 !== 10'd220) begin miscompares++; $display("FAIL mid_rst_p1: got %0d expected 220", p1); end
    if (pv !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b expected 0", pv); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 7; i++) send_sample(2048, 2048);
    vectors++;
    if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL mid_rst_early: got %0d expected %0d", pulse_cnt, exp_pulses); end
    send_sample(2048, 2048);
    vectors += 3;
    if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL mid_rst_pulse: got %0d expected %0d", pulse_cnt, exp_pulses); end
    if (p0 !== 10'd220) begin miscompares++; $display("FAIL mid_rst_blk_p0: got %0d expected 220", p0); end
    if (p1 !== 10'd220) begin miscompares++; $display("FAIL mid_rst_blk_p1: got %0d expected 220", p1); end
    $display("reset_mid_block: P0=%0d P1=%0d pulses=%0d", p0, p1, pulse_cnt);
  endtask

  task automatic test_glitch_overrun();
    int v0, v1;
    do_reset();
    // Sub-cycle low glitches between clock edges must never count as samples.
    for (int i = 0; i < 7; i++) begin
      send_sample(1000 + 300 * i, 3000 - 200 * i);
      repeat (2) begin
        @(negedge clk);
        #3 busy = 1'b0;
        #2 busy = 1'b1;
      end
    end
    vectors++;
    if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL glitch_count: got %0d expected %0d", pulse_cnt, exp_pulses); end
    send_sample(2900, 1600);
    vectors += 3;
    if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL glitch_pulse: got %0d expected %0d", pulse_cnt, exp_pulses); end
    if (p0 !== 10'(m0)) begin miscompares++; $display("FAIL glitch_p0: got %0d expected %0d", p0, m0); end
    if (p1 !== 10'(m1)) begin miscompares++; $display("FAIL glitch_p1: got %0d expected %0d", p1, m1); end
    $display("glitch: P0=%0d P1=%0d pulses=%0d", p0, p1, pulse_cnt);

    v0 = int'($urandom_range(0, 4095));
    v1 = int'($urandom_range(0, 4095));
    for (int i = 0; i < 7; i++) send_sample(v0, v1);
    // Final sample then two quick edges while the block is finishing:
    // the first is buffered, the second arrives while it is still pending.
    @(negedge clk);
    d0 = 12'(v0); d1 = 12'(v1); busy = 1'b0;
    @(negedge clk) busy = 1'b1;
    @(negedge clk) busy = 1'b0;
    @(negedge clk) busy = 1'b1;
    @(negedge clk) busy = 1'b0;
    @(negedge clk) busy = 1'b1;
    repeat (10) @(negedge clk);
    model_push(v0, v1);
    model_push(v0, v1);
    vectors += 2;
    if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL ovr_pulse: got %0d expected %0d", pulse_cnt, exp_pulses); end
    if (p0 !== 10'(m0)) begin miscompares++; $display("FAIL ovr_p0: got %0d expected %0d", p0, m0); end
    for (int i = 0; i < 6; i++) send_sample(v0, v1);
    vectors++;
    if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL ovr_dropped: got %0d expected %0d", pulse_cnt, exp_pulses); end
    send_sample(v0, v1);
    vectors += 3;
    if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL ovr_next_block: got %0d expected %0d", pulse_cnt, exp_pulses); end
    if (p0 !== 10'(m0)) begin miscompares++; $display("FAIL ovr_blk_p0: got %0d expected %0d", p0, m0); end
    if (p1 !== 10'(m1)) begin miscompares++; $display("FAIL ovr_blk_p1: got %0d expected %0d", p1, m1); end
    $display("overrun: data=%0d/%0d P0=%0d P1=%0d pulses=%0d", v0, v1, p0, p1, pulse_cnt);
  endtask

  task automatic test_random();
    int b0 = 0, b1 = 0, a, b;
    for (int blk = 0; blk < 6; blk++) begin
      // Odd blocks stay near the previous level to land inside the deadband.
      if (blk % 2 == 0) begin
        b0 = int'($urandom_range(0, 4095));
        b1 = int'($urandom_range(0, 4095));
      end
      for (int s = 0; s < AVG_N; s++) begin
        a = b0 + int'($urandom_range(0, 24)) - 12;
        b = b1 + int'($urandom_range(0, 24)) - 12;
        a = (a < 0) ? 0 : (a > 4095) ? 4095 : a;
        b = (b < 0) ? 0 : (b > 4095) ? 4095 : b;
        send_sample(a, b);
      end
      vectors += 4;
      if (p0 !== 10'(m0)) begin miscompares++; $display("FAIL rand_p0[%0d]: got %0d expected %0d", blk, p0, m0); end
      if (p1 !== 10'(m1)) begin miscompares++; $display("FAIL rand_p1[%0d]: got %0d expected %0d", blk, p1, m1); end
      if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL rand_pulses[%0d]: got %0d expected %0d", blk, pulse_cnt, exp_pulses); end
      if (stall !== 1'b0) begin miscompares++; $display("FAIL rand_stall[%0d]: got %b expected 0", blk, stall); end
      $display("random block %0d: base=%0d/%0d P0=%0d P1=%0d", blk, b0, b1, p0, p1);
    end
  endtask

`ifdef ADC_WATCHDOG_EN
  task automatic test_watchdog();
    int hit = 0;
    do_reset();
    for (int i = 0; i < 8; i++) send_sample(4095, 4095);
    vectors++;
    if (p0 !== 10'd440) begin miscompares++; $display("FAIL wd_pre_p0: got %0d expected 440", p0); end
    for (int k = 1; k <= 1100 && hit == 0; k++) begin
      @(negedge clk);
      if (stall === 1'b1) hit = k;
    end
    repeat (4) @(negedge clk);
    model_reset();
    exp_pulses++;
    vectors += 4;
    // Last edge detected ~2 cycles after its drive, send_sample returns 12 cycles after drive.
    if (hit < 982 || hit > 1002) begin miscompares++; $display("FAIL wd_timeout: got %0d expected 982..1002", hit); end
    if (p0 !== 10'd220) begin miscompares++; $display("FAIL wd_p0: got %0d expected 220", p0); end
    if (p1 !== 10'd220) begin miscompares++; $display("FAIL wd_p1: got %0d expected 220", p1); end
    if (pulse_cnt !== exp_pulses) begin miscompares++; $display("FAIL wd_pulse: got %0d expected %0d", pulse_cnt, exp_pulses); end
    send_sample(2048, 2048);
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL wd_clear: got %b expected 0", stall); end
    $display("watchdog: stall after %0d cycles, P0=%0d P1=%0d", hit, p0, p1);
  endtask
`endif

  initial begin
    test_reset();
    test_full_scale();
    test_deadband();
    test_reset_mid_block();
    test_glitch_overrun();
    test_random();
`ifdef ADC_WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
